// File: rtl/rr_mux_arbiter4_pkg.sv
// Shared definitions for the rr_mux_arbiter4 slice.
//   NUM_REQ  : number of requesters sharing the output bus
//   DATA_W   : data width per requester (fixed by the Mux4to1b4 datapath)
//   state_e  : arbiter FSM states
//   rr_pick  : round-robin priority pick starting after the last winner
package rr_mux_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The loop walks that
  // order backwards so the highest-priority hit is written last and wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [1:0]         ptr);
    pick_t      p;
    logic [1:0] idx;
    p = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter4_if.sv
// Bus bundle between 4 producer channels, the arbiter and one consumer.
//   req[3:0]   per-requester request          last[3:0]  per-requester end of packet
//   I0..I3     per-requester data             ready      consumer accepts current beat
//   gnt[3:0]   one-hot grant                  sel[1:0]   current/last winner index
//   valid      beat on O is valid             O          muxed data I[sel]
//   busy       arbiter is holding a grant
// slave  : arbiter side
// master : producer/consumer side
interface rr_mux_arbiter4_if;
  import rr_mux_arbiter4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  I0;
  logic [DATA_W-1:0]  I1;
  logic [DATA_W-1:0]  I2;
  logic [DATA_W-1:0]  I3;
  logic [NUM_REQ-1:0] last;
  logic               ready;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         sel;
  logic               valid;
  logic [DATA_W-1:0]  O;
  logic               busy;

  modport slave (
    input  req, I0, I1, I2, I3, last, ready,
    output gnt, sel, valid, O, busy
  );

  modport master (
    output req, I0, I1, I2, I3, last, ready,
    input  gnt, sel, valid, O, busy
  );

endinterface

// File: rtl/rr_mux_arbiter4_mux.sv
// Mux4to1b4: 4-to-1 multiplexer, 4 bits wide.
//   S      : 2-bit select
//   I0..I3 : data inputs
//   O      : I[S]
module Mux4to1b4 (
  input  logic [1:0] S,
  input  logic [3:0] I0,
  input  logic [3:0] I1,
  input  logic [3:0] I2,
  input  logic [3:0] I3,
  output logic [3:0] O
);

  always_comb begin
    unique case (S)
      2'd0:    O = I0;
      2'd1:    O = I1;
      2'd2:    O = I2;
      default: O = I3;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// rr_mux_arbiter4: round-robin arbiter sharing one 4-bit bus among 4 requesters.
// A grant is held for a whole packet and ends on an accepted beat with last,
// after MAX_BEATS accepted beats, or when the granted requester withdraws.
// One IDLE bubble always separates consecutive grants.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : rr_mux_arbiter4_if.slave (req/I0..I3/last/ready in, gnt/sel/valid/O/busy out)
module rr_mux_arbiter4
  import rr_mux_arbiter4_pkg::*;
#(
  parameter int MAX_BEATS = 8
) (
  input logic                clk,
  input logic                rst,
  rr_mux_arbiter4_if.slave   bus
);

  // Counter is one bit wider than needed so MAX_BEATS=1 still has a legal width.
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_c;
  logic               valid_c;
  logic               busy_c;
  pick_t              pick;

  assign pick = rr_pick(bus.req, ptr_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_c   = '0;
    valid_c = 1'b0;
    busy_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          sel_d   = pick.idx;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        gnt_c   = NUM_REQ'(1) << sel_q;
        busy_c  = 1'b1;
        valid_c = bus.req[sel_q];
        if (!bus.req[sel_q]) begin
          // Requester withdrew: release without transferring a beat.
          ptr_d   = sel_q;
          state_d = ST_IDLE;
        end else if (bus.ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.last[sel_q] || (cnt_q == CNT_W'(MAX_BEATS - 1))) begin
            ptr_d   = sel_q;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt   = gnt_c;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_c;
  assign bus.busy  = busy_c;

  // sel holds in IDLE, so O keeps showing the previous winner's data.
  Mux4to1b4 u_mux (
    .S  (sel_q),
    .I0 (bus.I0),
    .I1 (bus.I1),
    .I2 (bus.I2),
    .I3 (bus.I3),
    .O  (bus.O)
  );

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Testbench for rr_mux_arbiter4 (MAX_BEATS = 8).
// Directed vector table, hand-written multi-cycle sequences, then randomized
// traffic compared against a packet-level reference model.
module tb_rr_mux_arbiter4;

  localparam int MAX_BEATS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_mux_arbiter4_if bus ();

  rr_mux_arbiter4 #(.MAX_BEATS(MAX_BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: owner of the bus (-1 when idle), last winner, mux select
  // and number of beats accepted in the current packet.
  int m_owner = -1;
  int m_ptr   = 3;
  int m_sel   = 0;
  int m_beats = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic        ready;
    logic [15:0] din;
    logic [3:0]  eg;
    logic        ev;
    logic        eb;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int rr_first(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 3; m_beats = 0;
    end else if (m_owner < 0) begin
      if (bus.req != 4'b0000) begin
        m_owner = rr_first(bus.req, m_ptr);
        m_sel   = m_owner;
        m_beats = 0;
      end
    end else if (!bus.req[m_owner]) begin
      m_ptr = m_owner; m_owner = -1;
    end else if (bus.ready) begin
      m_beats++;
      if (bus.last[m_owner] || m_beats == MAX_BEATS) begin
        m_ptr = m_owner; m_owner = -1;
      end
    end
  endfunction

  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                              input logic rdy, input logic [15:0] d, input logic [3:0] eg,
                              input logic ev, input logic eb, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.req = rq; v.last = lst; v.ready = rdy; v.din = d;
    v.eg = eg; v.ev = ev; v.eb = eb; v.es = es;
    tbl.push_back(v);
  endfunction

  // Called just after a rising edge: drive, check mid-cycle, then advance.
  task automatic do_cycle(input string tag, input vec_t v);
    logic [15:0] d;
    logic [3:0]  exp_o;
    rst       = v.rst;
    bus.req   = v.req;
    bus.last  = v.last;
    bus.ready = v.ready;
    bus.I0    = v.din[3:0];
    bus.I1    = v.din[7:4];
    bus.I2    = v.din[11:8];
    bus.I3    = v.din[15:12];
    d         = v.din;
    exp_o     = 4'(d >> (4 * v.es));
    @(negedge clk);
    check({tag, ".gnt"},   32'(bus.gnt),   32'(v.eg));
    check({tag, ".valid"}, 32'(bus.valid), 32'(v.ev));
    check({tag, ".busy"},  32'(bus.busy),  32'(v.eb));
    check({tag, ".sel"},   32'(bus.sel),   32'(v.es));
    check({tag, ".O"},     32'(bus.O),     32'(exp_o));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic hand(input string tag, input logic r, input logic [3:0] rq,
                      input logic [3:0] lst, input logic rdy, input logic [3:0] eg,
                      input logic ev, input logic eb, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.req = rq; v.last = lst; v.ready = rdy; v.din = 16'hDCBA;
    v.eg = eg; v.ev = ev; v.eb = eb; v.es = es;
    do_cycle(tag, v);
  endtask

  initial begin
    bus.req = '0; bus.last = '0; bus.ready = 1'b0;
    bus.I0 = '0; bus.I1 = '0; bus.I2 = '0; bus.I3 = '0;
    repeat (2) begin
      @(posedge clk);
      model_update();
    end
    #1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) add(0, 4'b0000, 4'b0000, 0, 16'h4321, 4'b0000, 0, 0, 2'd0);
    // Full rotation with single-beat packets and a bubble between grants.
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0001, 1, 1, 2'd0);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0010, 1, 1, 2'd1);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0000, 0, 0, 2'd1);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0100, 1, 1, 2'd2);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0000, 0, 0, 2'd2);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b1000, 1, 1, 2'd3);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0000, 0, 0, 2'd3);
    add(0, 4'b1111, 4'b1111, 1, 16'h4321, 4'b0001, 1, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 0, 16'h4321, 4'b0000, 0, 0, 2'd0);
    // Requester 2 alone: 3-beat packet, ready 1,0,1,0,1, I2 changes per beat.
    add(0, 4'b0100, 4'b0000, 0, 16'h4521, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b0100, 4'b0000, 1, 16'h4621, 4'b0100, 1, 1, 2'd2);
    add(0, 4'b0100, 4'b0000, 0, 16'h4721, 4'b0100, 1, 1, 2'd2);
    add(0, 4'b0100, 4'b0000, 1, 16'h4821, 4'b0100, 1, 1, 2'd2);
    add(0, 4'b0100, 4'b0000, 0, 16'h4921, 4'b0100, 1, 1, 2'd2);
    add(0, 4'b0100, 4'b0100, 1, 16'h4A21, 4'b0100, 1, 1, 2'd2);
    add(0, 4'b0000, 4'b0000, 0, 16'h4B21, 4'b0000, 0, 0, 2'd2);

    for (int i = 0; i < tbl.size(); i++) do_cycle($sformatf("vec%0d", i), tbl[i]);

    // MAX_BEATS forced rotation: requester 1 never sends last.
    hand("mb_rst",  1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd2);
    hand("mb_arb",  0, 4'b0110, 4'b0000, 1, 4'b0000, 0, 0, 2'd0);
    for (int i = 0; i < MAX_BEATS; i++)
      hand($sformatf("mb_beat%0d", i), 0, 4'b0110, 4'b0000, 1, 4'b0010, 1, 1, 2'd1);
    hand("mb_gap",  0, 4'b0110, 4'b0000, 1, 4'b0000, 0, 0, 2'd1);
    hand("mb_next", 0, 4'b0000, 4'b0000, 1, 4'b0100, 0, 1, 2'd2);

    // Requester 3 withdraws mid-packet; rotation continues at requester 0.
    hand("wd_arb",  0, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 2'd2);
    hand("wd_beat", 0, 4'b1000, 4'b0000, 1, 4'b1000, 1, 1, 2'd3);
    hand("wd_drop", 0, 4'b0000, 4'b0000, 1, 4'b1000, 0, 1, 2'd3);
    hand("wd_idle", 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 2'd3);
    hand("wd_next", 0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 1, 2'd0);

    // Reset during a grant to requester 1.
    hand("rs_arb",  0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 2'd0);
    hand("rs_beat", 0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 2'd1);
    hand("rs_hit",  1, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 2'd1);
    hand("rs_post", 0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 2'd0);
    hand("rs_gnt",  0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 1, 2'd0);
    hand("rs_end",  0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);

    // Randomized traffic against the reference model.
    hand("rnd_rst", 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      v.rst   = ($urandom_range(99) == 0);
      for (int b = 0; b < 4; b++) begin
        v.req[b]  = ($urandom_range(7) != 0);
        v.last[b] = ($urandom_range(5) == 0);
      end
      v.ready = ($urandom_range(2) != 0);
      v.din   = 16'($urandom);
      v.eg    = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      v.ev    = (m_owner >= 0) && v.req[m_owner];
      v.eb    = (m_owner >= 0);
      v.es    = 2'(m_sel);
      do_cycle($sformatf("rnd%0d", i), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
